// File: rtl/dma_if_pkg.sv
// Shared types for the im2col single-channel parameter generator: the DMA
// descriptor, the job configuration and the generator FSM states.
package dma_if_pkg;

    typedef struct packed {
        logic [31:0] input_ptr;
        logic [31:0] output_ptr;
        logic [22:0] in_inc_d2;
        logic [15:0] size_du_d1;
        logic [15:0] size_du_d2;
        logic [7:0]  n_zeros_left;
        logic [7:0]  n_zeros_right;
        logic [7:0]  n_zeros_top;
        logic [7:0]  n_zeros_bottom;
    } dma_if_t;

    typedef struct packed {
        logic [31:0] src_ptr;
        logic [31:0] dst_ptr;
        logic [15:0] iw;
        logic [15:0] ih;
        logic [15:0] ch;
        logic [7:0]  fw;
        logic [7:0]  fh;
        logic [7:0]  pad_t;
        logic [7:0]  pad_b;
        logic [7:0]  pad_l;
        logic [7:0]  pad_r;
        logic [1:0]  dsize;
    } im2col_cfg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_CALC,
        ST_VALID,
        ST_DONE
    } im2col_state_e;

    // Clamp a two's-complement 32-bit value at zero.
    function automatic logic [31:0] sat0(input logic [31:0] x);
        return x[31] ? '0 : x;
    endfunction

    function automatic logic cfg_invalid(input im2col_cfg_t c);
        logic [31:0] span_w;
        logic [31:0] span_h;
        span_w = 32'(c.iw) + 32'(c.pad_l) + 32'(c.pad_r);
        span_h = 32'(c.ih) + 32'(c.pad_t) + 32'(c.pad_b);
        return (c.fw == '0) || (c.fh == '0) || (c.ch == '0) ||
               (c.pad_l >= c.fw) || (c.pad_r >= c.fw) ||
               (c.pad_t >= c.fh) || (c.pad_b >= c.fh) ||
               (32'(c.fw) > span_w) || (32'(c.fh) > span_h) ||
               (c.dsize == 2'd3);
    endfunction

endpackage

// File: rtl/im2col_spc_desc_calc.sv
// Combinational descriptor arithmetic for one (c, kh, kw) filter tap.
module im2col_spc_desc_calc
    import dma_if_pkg::*;
(
    input  im2col_cfg_t cfg_i,
    input  logic [15:0] c_i,
    input  logic [7:0]  kh_i,
    input  logic [7:0]  kw_i,
    output dma_if_t     desc_o
);

    logic [31:0] ow, oh;
    logic [31:0] zl, zr, zt, zb;
    logic [31:0] row, col, in_off, out_idx, out_off;
    logic        unused_cfg;

    assign unused_cfg = ^cfg_i.ch;

    always_comb begin
        ow = 32'(cfg_i.iw) + 32'(cfg_i.pad_l) + 32'(cfg_i.pad_r) - 32'(cfg_i.fw) + 32'd1;
        oh = 32'(cfg_i.ih) + 32'(cfg_i.pad_t) + 32'(cfg_i.pad_b) - 32'(cfg_i.fh) + 32'd1;

        zl = sat0(32'(cfg_i.pad_l) - 32'(kw_i));
        zr = sat0(ow + 32'(kw_i) - 32'(cfg_i.pad_l) - 32'(cfg_i.iw));
        zt = sat0(32'(cfg_i.pad_t) - 32'(kh_i));
        zb = sat0(oh + 32'(kh_i) - 32'(cfg_i.pad_t) - 32'(cfg_i.ih));

        // First non-padding source pixel touched by this tap, all modulo 2^32.
        row    = 32'(c_i) * 32'(cfg_i.ih) + 32'(kh_i) - 32'(cfg_i.pad_t) + zt;
        col    = 32'(kw_i) - 32'(cfg_i.pad_l) + zl;
        in_off = (row * 32'(cfg_i.iw) + col) << cfg_i.dsize;

        out_idx = (32'(c_i) * 32'(cfg_i.fh) + 32'(kh_i)) * 32'(cfg_i.fw) + 32'(kw_i);
        out_off = (out_idx * oh * ow) << cfg_i.dsize;

        desc_o.input_ptr      = cfg_i.src_ptr + in_off;
        desc_o.output_ptr     = cfg_i.dst_ptr + out_off;
        desc_o.in_inc_d2      = 23'(cfg_i.iw) << cfg_i.dsize;
        desc_o.size_du_d1     = 16'(ow - zl - zr);
        desc_o.size_du_d2     = 16'(oh - zt - zb);
        desc_o.n_zeros_left   = 8'(zl);
        desc_o.n_zeros_right  = 8'(zr);
        desc_o.n_zeros_top    = 8'(zt);
        desc_o.n_zeros_bottom = 8'(zb);
    end

endmodule

// File: rtl/im2col_spc_param_gen.sv
// im2col parameter generator: walks (c, kh, kw) and hands one DMA descriptor
// per filter tap to a downstream DMA programmer with a valid/ready handshake.
module im2col_spc_param_gen
    import dma_if_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  im2col_cfg_t cfg_i,
    output dma_if_t     dma_if_o,
    output logic        dma_valid_o,
    input  logic        dma_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    im2col_state_e state_q, state_d;
    im2col_cfg_t   cfg_q, cfg_d;
    logic [15:0]   c_q, c_d;
    logic [7:0]    kh_q, kh_d;
    logic [7:0]    kw_q, kw_d;
    logic          err_q, err_d;
    dma_if_t       desc_q, desc_d;
    dma_if_t       desc_calc;
    logic          kw_last, kh_last, c_last;

    im2col_spc_desc_calc u_desc_calc (
        .cfg_i  (cfg_q),
        .c_i    (c_q),
        .kh_i   (kh_q),
        .kw_i   (kw_q),
        .desc_o (desc_calc)
    );

    assign kw_last = (kw_q == cfg_q.fw - 8'd1);
    assign kh_last = (kh_q == cfg_q.fh - 8'd1);
    assign c_last  = (c_q  == cfg_q.ch - 16'd1);

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        c_d     = c_q;
        kh_d    = kh_q;
        kw_d    = kw_q;
        err_d   = err_q;
        desc_d  = desc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cfg_d   = cfg_i;
                    err_d   = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cfg_invalid(cfg_q)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    c_d     = '0;
                    kh_d    = '0;
                    kw_d    = '0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                desc_d  = desc_calc;
                state_d = ST_VALID;
            end
            ST_VALID: begin
                if (dma_ready_i) begin
                    // kw innermost, then kh, then c.
                    if (kw_last) begin
                        kw_d = '0;
                        if (kh_last) begin
                            kh_d = '0;
                            c_d  = c_q + 16'd1;
                        end else begin
                            kh_d = kh_q + 8'd1;
                        end
                    end else begin
                        kw_d = kw_q + 8'd1;
                    end
                    state_d = (kw_last && kh_last && c_last) ? ST_DONE : ST_CALC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            c_q     <= '0;
            kh_q    <= '0;
            kw_q    <= '0;
            err_q   <= 1'b0;
            desc_q  <= '0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            c_q     <= c_d;
            kh_q    <= kh_d;
            kw_q    <= kw_d;
            err_q   <= err_d;
            desc_q  <= desc_d;
        end
    end

    assign dma_if_o    = desc_q;
    assign dma_valid_o = (state_q == ST_VALID);
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = err_q;

endmodule

// File: tb/tb_im2col_spc_param_gen.sv
// Self-checking bench for im2col_spc_param_gen: descriptor model plus
// hand-computed literal expectations for the reference configurations.
module tb_im2col_spc_param_gen;
    import dma_if_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    im2col_cfg_t cfg_i;
    dma_if_t     dma_if_o;
    logic        dma_valid_o;
    logic        dma_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int          cyc = 0;
    int          n_valid = 0;
    int          first_valid = -1;
    dma_if_t     exp_q[$];
    dma_if_t     got_q[$];

    im2col_spc_param_gen dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .cfg_i       (cfg_i),
        .dma_if_o    (dma_if_o),
        .dma_valid_o (dma_valid_o),
        .dma_ready_i (dma_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_desc(input string name, input dma_if_t act, input dma_if_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint mx0(input longint x);
        return (x < 0) ? 64'sd0 : x;
    endfunction

    function automatic bit cfg_ok(input im2col_cfg_t g);
        longint iw, ih, ch, fw, fh, pt, pb, pl, pr, ds;
        iw = g.iw; ih = g.ih; ch = g.ch; fw = g.fw; fh = g.fh;
        pt = g.pad_t; pb = g.pad_b; pl = g.pad_l; pr = g.pad_r; ds = g.dsize;
        return !(fw == 0 || fh == 0 || ch == 0 || pl >= fw || pr >= fw ||
                 pt >= fh || pb >= fh || fw > iw + pl + pr || fh > ih + pt + pb || ds == 3);
    endfunction

    function automatic dma_if_t model_desc(input im2col_cfg_t g, input longint c,
                                           input longint kh, input longint kw);
        longint iw, ih, fw, fh, pt, pb, pl, pr, ds;
        longint ow, oh, zl, zr, zt, zb, in_off, out_off;
        dma_if_t d;
        iw = g.iw; ih = g.ih; fw = g.fw; fh = g.fh;
        pt = g.pad_t; pb = g.pad_b; pl = g.pad_l; pr = g.pad_r; ds = g.dsize;
        ow = iw + pl + pr - fw + 1;
        oh = ih + pt + pb - fh + 1;
        zl = mx0(pl - kw);
        zr = mx0(ow + kw - pl - iw);
        zt = mx0(pt - kh);
        zb = mx0(oh + kh - pt - ih);
        in_off  = ((c * ih + kh - pt + zt) * iw + kw - pl + zl) << ds;
        out_off = (((c * fh + kh) * fw + kw) * oh * ow) << ds;
        d.input_ptr      = g.src_ptr + in_off[31:0];
        d.output_ptr     = g.dst_ptr + out_off[31:0];
        d.in_inc_d2      = 23'(iw << ds);
        d.size_du_d1     = 16'(ow - zl - zr);
        d.size_du_d2     = 16'(oh - zt - zb);
        d.n_zeros_left   = 8'(zl);
        d.n_zeros_right  = 8'(zr);
        d.n_zeros_top    = 8'(zt);
        d.n_zeros_bottom = 8'(zb);
        return d;
    endfunction

    function automatic int plan_job(input im2col_cfg_t g);
        int n = 0;
        exp_q.delete();
        if (cfg_ok(g)) begin
            for (int c = 0; c < int'(g.ch); c++)
                for (int kh = 0; kh < int'(g.fh); kh++)
                    for (int kw = 0; kw < int'(g.fw); kw++) begin
                        exp_q.push_back(model_desc(g, c, kh, kw));
                        n++;
                    end
        end
        return n;
    endfunction

    function automatic im2col_cfg_t mk_cfg(input logic [31:0] src, input logic [31:0] dst,
        input int iw, input int ih, input int ch, input int fw, input int fh,
        input int pt, input int pb, input int pl, input int pr, input int ds);
        im2col_cfg_t g;
        g.src_ptr = src; g.dst_ptr = dst;
        g.iw = 16'(iw); g.ih = 16'(ih); g.ch = 16'(ch);
        g.fw = 8'(fw); g.fh = 8'(fh);
        g.pad_t = 8'(pt); g.pad_b = 8'(pb); g.pad_l = 8'(pl); g.pad_r = 8'(pr);
        g.dsize = 2'(ds);
        return g;
    endfunction

    // ---------------- per-cycle compare process ----------------
    dma_if_t prev_desc;
    logic    prev_v = 1'b0;
    logic    prev_r = 1'b0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("hold_valid", 64'(dma_valid_o), 64'd1);
                chk_desc("hold_desc", dma_if_o, prev_desc);
            end
            if (prev_v && prev_r)
                chk("gap_after_accept", 64'(dma_valid_o), 64'd0);
            if (dma_valid_o) begin
                n_valid++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (dma_valid_o && dma_ready_i) begin
                got_q.push_back(dma_if_o);
                if (exp_q.size() == 0) fail_now("extra_descriptor");
                else chk_desc("desc", dma_if_o, exp_q.pop_front());
            end
            prev_v    = dma_valid_o;
            prev_r    = dma_ready_i;
            prev_desc = dma_if_o;
        end
    end

    // ---------------- job helpers ----------------
    task automatic start_job(input im2col_cfg_t g, input logic rdy, output int s, output int n);
        cfg_i = g;
        n = plan_job(g);
        got_q.delete();
        n_valid = 0;
        first_valid = -1;
        @(posedge clk_i); #1;
        start_i = 1'b1;
        dma_ready_i = rdy;
        s = cyc;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        chk("busy_after_start", 64'(busy_o), 64'd1);
        chk("err_cleared_on_start", 64'(err_o), 64'd0);
    endtask

    task automatic wait_done(input int max, input bit rnd, output int dcyc);
        dcyc = -1;
        for (int i = 0; i < max; i++) begin
            if (done_o) begin
                dcyc = cyc;
                break;
            end
            if (rnd) begin
                @(posedge clk_i); #1;
                dma_ready_i = 1'($urandom_range(0, 1));
            end
            @(negedge clk_i);
        end
        if (dcyc < 0) begin
            fail_now("wait_done");
        end else begin
            @(negedge clk_i);
            chk("done_one_cycle", 64'(done_o), 64'd0);
            chk("idle_after_done", 64'(busy_o), 64'd0);
            chk("all_desc_emitted", 64'(exp_q.size()), 64'd0);
        end
    endtask

    im2col_cfg_t cfg_a, cfg_b, cfg_c, cfg_e1, cfg_e2, cfg_e3;

    initial begin
        int s, n, d;
        rst_ni = 1'b0;
        start_i = 1'b0;
        dma_ready_i = 1'b1;
        cfg_i = '0;
        cfg_a  = mk_cfg(32'h1000, 32'h2000, 4, 4, 1, 3, 3, 1, 1, 1, 1, 2);
        cfg_b  = mk_cfg(32'h8000_0000, 32'h4000, 5, 5, 2, 2, 2, 0, 0, 0, 0, 0);
        cfg_c  = mk_cfg(32'hFFFF_FF00, 32'h10, 6, 3, 3, 2, 3, 2, 1, 1, 0, 1);
        cfg_e1 = mk_cfg(32'h1000, 32'h2000, 4, 4, 1, 3, 3, 1, 1, 3, 1, 2);
        cfg_e2 = mk_cfg(32'h1000, 32'h2000, 4, 4, 1, 3, 3, 1, 1, 1, 1, 3);
        cfg_e3 = mk_cfg(32'h1000, 32'h2000, 4, 4, 1, 0, 3, 0, 1, 0, 0, 2);

        // Reset state
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_valid", 64'(dma_valid_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk_desc("rst_desc", dma_if_o, '0);

        // Reference job A: 9 descriptors, literal pins
        start_job(cfg_a, 1'b1, s, n);
        chk("a_planned", 64'(n), 64'd9);
        wait_done(100, 1'b0, d);
        chk("a_latency", 64'(first_valid - s), 64'd3);
        chk("a_count", 64'(got_q.size()), 64'd9);
        if (got_q.size() == 9) begin
            chk("a0_in", 64'(got_q[0].input_ptr), 64'h1000);
            chk("a0_out", 64'(got_q[0].output_ptr), 64'h2000);
            chk("a0_zl", 64'(got_q[0].n_zeros_left), 64'd1);
            chk("a0_zt", 64'(got_q[0].n_zeros_top), 64'd1);
            chk("a0_d1", 64'(got_q[0].size_du_d1), 64'd3);
            chk("a0_d2", 64'(got_q[0].size_du_d2), 64'd3);
            chk("a0_inc", 64'(got_q[0].in_inc_d2), 64'd16);
            chk("a2_in", 64'(got_q[2].input_ptr), 64'h1004);
            chk("a2_out", 64'(got_q[2].output_ptr), 64'h2080);
            chk("a2_zr", 64'(got_q[2].n_zeros_right), 64'd1);
            chk("a8_in", 64'(got_q[8].input_ptr), 64'h1014);
            chk("a8_out", 64'(got_q[8].output_ptr), 64'h2200);
            chk("a8_zb", 64'(got_q[8].n_zeros_bottom), 64'd1);
        end

        // Job B, with an ignored start pulse mid-job
        start_job(cfg_b, 1'b1, s, n);
        repeat (3) @(posedge clk_i);
        #1 cfg_i = cfg_a;
        start_i = 1'b1;
        @(posedge clk_i); #1 start_i = 1'b0;
        wait_done(100, 1'b0, d);
        chk("b_count", 64'(got_q.size()), 64'd8);
        chk("b_valid_cycles", 64'(n_valid), 64'd8);
        if (got_q.size() == 8) begin
            chk("b4_in", 64'(got_q[4].input_ptr), 64'h8000_0019);
            chk("b4_out", 64'(got_q[4].output_ptr), 64'h4040);
            chk("b4_d1", 64'(got_q[4].size_du_d1), 64'd4);
            chk("b4_d2", 64'(got_q[4].size_du_d2), 64'd4);
            chk("b4_inc", 64'(got_q[4].in_inc_d2), 64'd5);
            chk("b4_zl", 64'(got_q[4].n_zeros_left), 64'd0);
        end
        @(negedge clk_i);
        chk("b_no_restart", 64'(busy_o), 64'd0);

        // Job A with ready held low for 10 cycles on the first descriptor
        start_job(cfg_a, 1'b0, s, n);
        repeat (12) @(posedge clk_i);
        #1 dma_ready_i = 1'b1;
        wait_done(100, 1'b0, d);
        chk("stall_count", 64'(got_q.size()), 64'd9);

        // Config errors
        start_job(cfg_e1, 1'b1, s, n);
        wait_done(10, 1'b0, d);
        chk("e1_done_cycle", 64'(d - s), 64'd2);
        chk("e1_err", 64'(err_o), 64'd1);
        chk("e1_no_valid", 64'(n_valid), 64'd0);
        start_job(cfg_e2, 1'b1, s, n);
        wait_done(10, 1'b0, d);
        chk("e2_err", 64'(err_o), 64'd1);
        chk("e2_no_valid", 64'(n_valid), 64'd0);
        start_job(cfg_e3, 1'b1, s, n);
        wait_done(10, 1'b0, d);
        chk("e3_err", 64'(err_o), 64'd1);
        chk("e3_no_valid", 64'(n_valid), 64'd0);

        // Job C with random backpressure and a wrapping source pointer
        start_job(cfg_c, 1'b1, s, n);
        wait_done(400, 1'b1, d);
        chk("c_count", 64'(got_q.size()), 64'(n));
        chk("c_err", 64'(err_o), 64'd0);

        // Asynchronous reset while a descriptor is valid
        start_job(cfg_a, 1'b0, s, n);
        d = -1;
        for (int i = 0; i < 10; i++) begin
            if (dma_valid_o) begin
                d = cyc;
                break;
            end
            @(negedge clk_i);
        end
        if (d < 0) fail_now("wait_valid_before_reset");
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(dma_valid_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_done", 64'(done_o), 64'd0);
        chk_desc("arst_desc", dma_if_o, '0);
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        dma_ready_i = 1'b1;
        exp_q.delete();
        start_job(cfg_a, 1'b1, s, n);
        wait_done(100, 1'b0, d);
        chk("rerun_count", 64'(got_q.size()), 64'd9);
        if (got_q.size() == 9)
            chk("rerun_first_in", 64'(got_q[0].input_ptr), 64'h1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/im2col_spc_param_gen.md
IM2COL_SPC_PARAM_GEN -- requirements
Module: im2col_spc_param_gen

Interface
REQ-001 No parameters; all widths are fixed by the shared package.
REQ-002 clk_i  in  1  single clock, rising edge.
REQ-003 rst_ni  in  1  asynchronous, active-low reset.
REQ-004 start_i  in  1  one-cycle start pulse; honoured only in IDLE.
REQ-005 cfg_i  in  im2col_cfg_t  src_ptr[31:0], dst_ptr[31:0], iw[15:0], ih[15:0], ch[15:0], fw[7:0], fh[7:0], pad_t/b/l/r[7:0], dsize[1:0] (0=byte, 1=half, 2=word).
REQ-006 dma_if_o  out  dma_if_t  current DMA transaction descriptor.
REQ-007 dma_valid_o  out  1  descriptor valid.
REQ-008 dma_ready_i  in  1  downstream DMA programmer accepts the descriptor.
REQ-009 busy_o  out  1  high from the cycle after an accepted start until done.
REQ-010 done_o  out  1  one-cycle pulse at job end.
REQ-011 err_o  out  1  sticky config-error flag; cleared by the next accepted start.

Function
REQ-012 Derived values: OW = iw+pad_l+pad_r-fw+1, OH = ih+pad_t+pad_b-fh+1 (stride 1); byte shift = dsize.
REQ-013 States: IDLE, CHECK, CALC, VALID, DONE.
REQ-014 IDLE and start_i -> latch cfg_i, clear err_o, go to CHECK; start_i in any other state is ignored.
REQ-015 CHECK (1 cycle): if fw==0, fh==0, ch==0, pad_l>=fw, pad_r>=fw, pad_t>=fh, pad_b>=fh, fw>iw+pad_l+pad_r, fh>ih+pad_t+pad_b, or dsize==3, set err_o and go to DONE; otherwise clear counters c, kh, kw to 0 and go to CALC.
REQ-016 CALC (1 cycle): register all dma_if_o fields from (c, kh, kw), then go to VALID.
REQ-017 Field rules:
- n_zeros_left = max(0, pad_l-kw); n_zeros_right = max(0, OW+kw-pad_l-iw).
- n_zeros_top = max(0, pad_t-kh); n_zeros_bottom = max(0, OH+kh-pad_t-ih).
- size_du_d1 = OW-left-right; size_du_d2 = OH-top-bottom.
- in_inc_d2 = iw<<dsize, zero-extended to 23 bits.
- input_ptr = src_ptr + (((c*ih + kh-pad_t+top)*iw + kw-pad_l+left) << dsize).
- output_ptr = dst_ptr + ((((c*fh+kh)*fw+kw)*OH*OW) << dsize).
- All pointer arithmetic is modulo 2^32.
REQ-018 VALID: dma_valid_o=1 and dma_if_o is held stable until dma_ready_i=1.
REQ-019 On acceptance, advance kw; at kw==fw-1 wrap kw to 0 and advance kh; at kh==fh-1 wrap kh to 0 and advance c.
REQ-020 After acceptance, go to CALC (valid low for exactly one cycle), or to DONE if the accepted descriptor had c==ch-1, kh==fh-1, kw==fw-1.
REQ-021 DONE (1 cycle): done_o=1, busy_o=0 in the following cycle, return to IDLE.
REQ-022 Exactly ch*fh*fw descriptors are emitted per job in (c, kh, kw) order, kw innermost; none are emitted on error.
REQ-023 Latency: start_i at cycle 0 -> dma_valid_o first high at cycle 3.

Reset
REQ-024 rst_ni low forces state IDLE and clears dma_valid_o, busy_o, done_o, err_o, counters and dma_if_o to 0 immediately, including mid-job; no partial descriptor survives.

Structure
REQ-025 dma_if_t stays in dma_if_pkg; im2col_cfg_t and the state enum are added to dma_if_pkg.
REQ-026 Field arithmetic sits in one combinational sub-module, im2col_spc_desc_calc, with inputs (cfg, c, kh, kw) and a dma_if_t output; the FSM, counters and output register sit in the top module.

Verification
REQ-027 Config iw=ih=4, ch=1, fw=fh=3, pads all 1, dsize=2, src=0x1000, dst=0x2000, ready=1 -> 9 descriptors:
- #0: in 0x1000, out 0x2000, zl=1, zt=1, d1=3, d2=3, inc=16.
- #2: in 0x1004, out 0x2080, zr=1.
- #8: in 0x1014, out 0x2200, zb=1.
- Then done_o.
REQ-028 Config iw=ih=5, ch=2, fw=fh=2, no pads, dsize=0 -> 8 descriptors, all zeros=0, d1=d2=4, inc=5; #4 in=src+25, out=dst+64.
REQ-029 dma_ready_i low for 10 cycles in VALID -> dma_valid_o stays 1 and dma_if_o stays bit-identical; descriptor count is unchanged.
REQ-030 pad_l=3 with fw=3 -> err_o=1, done_o pulses at cycle 2, dma_valid_o never high; next valid start clears err_o.
REQ-031 rst_ni asserted while dma_valid_o=1 -> all outputs 0 without waiting for a clock edge; a new start after release re-runs from descriptor #0.
REQ-032 start_i pulsed while busy -> ignored; job output and count are unaffected.
